timer_bank: RTL and testbench
=============================

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter csr_addr, default 4'h0, CSR bank select matched against csr_a[13:10].
REQ-002 SHALL have parameter ntimers, default 4, channel count, legal range 1..8.
REQ-003 SHALL have parameter width, default 32, counter/compare width, legal range 8..32.
REQ-004 SHALL have parameter prescale_width, default 16, global prescaler width.
REQ-005 SHALL have port sys_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port csr_a, input, 14, CSR address.
REQ-008 SHALL have port csr_we, input, 1, CSR write strobe.
REQ-009 SHALL have port csr_di, input, 32, CSR write data.
REQ-010 SHALL have port csr_do, output, 32, registered CSR read data.
REQ-011 SHALL have port timer_irq, output, ntimers, per-channel level interrupt: pending & irq_en.
REQ-012 SHALL have port irq, output, 1, registered OR of timer_irq.
REQ-013 SHALL have port capture_in, input, ntimers, asynchronous capture strobes (present only with TIMER_BANK_CAPTURE_EN).

Function
REQ-014 SHALL decode: select = (csr_a[13:10]==csr_addr); channel regs at csr_a[9]=0, channel = csr_a[6:4], reg = csr_a[1:0] (0 ctrl, 1 compare, 2 counter, 3 capture); global regs at csr_a[9]=1, csr_a[1:0] (0 pending, 1 prescale, 2 info).
REQ-015 SHALL return read data on csr_do one cycle after the address; csr_do = 0 when unselected or unmapped (including channel >= ntimers).
REQ-016 SHALL define ctrl bits: [0] en, [1] ar (auto-reload), [2] irq_en, [3] cap_en; unimplemented bits read 0.
REQ-017 SHALL run a global prescaler that counts 0..prescale and emits a one-cycle tick on wrap; prescale = 0 gives a tick every cycle.
REQ-018 SHALL, on tick with en=1 and counter != compare, increment the counter (modulo 2^width).
REQ-019 SHALL, on tick with en=1 and counter == compare, set pending[c]; with ar=1 reload the counter to 0; with ar=0 clear en and hold the counter.
REQ-020 SHALL make a CSR write to counter or ctrl win over the timer update in the same cycle.
REQ-021 SHALL make pending write-one-to-clear; a set event in the same cycle wins over the clear.
REQ-022 SHALL make a prescale write reset the prescaler count to 0.
REQ-023 SHALL make info read as {8'd0, prescale_width[7:0], width[7:0], capture_present, 3'd0, ntimers[3:0]}.
REQ-024 SHALL register irq, giving one cycle latency from timer_irq.

Reset
REQ-025 SHALL, on sys_rst_n low, asynchronously clear csr_do, irq, pending, all ctrl bits, counters, captures and the prescaler; compare resets to all-ones; prescale resets to 0.
REQ-026 SHALL make reset asserted mid-count abort all activity with no residual pending.

Configuration
REQ-027 SHALL, with TIMER_BANK_CAPTURE_EN defined, synchronise capture_in through 2 flops and, on a rising edge with cap_en=1, latch the counter into capture[c] and set pending[c].
REQ-028 SHALL, without TIMER_BANK_CAPTURE_EN, omit port capture_in, make capture and cap_en read 0, and make info bit 7 read 0.

Structure
REQ-029 SHALL place register offsets, ctrl bit positions and info field layout in shared package timer_bank_pkg.
REQ-030 SHALL implement one channel (counter, compare, ctrl, capture) as sub-module timer_bank_channel, instantiated ntimers times.

Verification
REQ-031 SHALL cover: prescale=0, compare=3, ctrl=0x7 -> pending[0] set and timer_irq[0] high on the 4th tick after enable; counter reloads to 0.
REQ-032 SHALL cover: prescale=9, compare=2, ar=0 -> match 30 cycles after enable, en reads 0, counter holds at 2.
REQ-033 SHALL cover: W1C pending on the same cycle as a match -> pending stays 1; next W1C clears it and irq drops 2 cycles later.
REQ-034 SHALL cover: counter write of 0x10 on the match cycle -> counter reads 0x10 and no reload.
REQ-035 SHALL cover: capture edge with counter=0x55 and cap_en=1 -> capture reads 0x55 and pending set 3 cycles after the edge (macro defined).
REQ-036 SHALL cover: reset asserted mid-count -> all registers return to reset values and info reads the parameter values.

Source files
------------

// File: rtl/timer_bank_pkg.sv
// Shared register map, ctrl bit positions and info layout for timer_bank.
// Capture support is compiled in with the TIMER_BANK_CAPTURE_EN macro.
package timer_bank_pkg;

  typedef enum logic [1:0] {
    CH_CTRL    = 2'd0,
    CH_COMPARE = 2'd1,
    CH_COUNTER = 2'd2,
    CH_CAPTURE = 2'd3
  } ch_reg_e;

  typedef enum logic [1:0] {
    GL_PENDING  = 2'd0,
    GL_PRESCALE = 2'd1,
    GL_INFO     = 2'd2,
    GL_NONE     = 2'd3
  } gl_reg_e;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AR     = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_CAP_EN = 3;

  localparam int INFO_NTIMERS_LSB  = 0;
  localparam int INFO_CAP_BIT      = 7;
  localparam int INFO_WIDTH_LSB    = 8;
  localparam int INFO_PRESCALE_LSB = 16;

  function automatic logic [31:0] make_info(input int nt, input int w, input int pw,
                                            input logic cap);
    logic [31:0] info;
    info = '0;
    info[INFO_NTIMERS_LSB +: 4]  = nt[3:0];
    info[INFO_CAP_BIT]           = cap;
    info[INFO_WIDTH_LSB +: 8]    = w[7:0];
    info[INFO_PRESCALE_LSB +: 8] = pw[7:0];
    return info;
  endfunction

endpackage

// File: rtl/timer_bank_channel.sv
// One timer channel: counter, compare, ctrl and (with TIMER_BANK_CAPTURE_EN)
// a capture register fed by an already-synchronised edge pulse.
module timer_bank_channel
  import timer_bank_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             tick,
  input  logic             wr_ctrl,
  input  logic             wr_compare,
  input  logic             wr_counter,
  input  logic [31:0]      wr_data,
  input  logic             cap_edge,
  output logic [3:0]       ctrl,
  output logic [width-1:0] compare,
  output logic [width-1:0] counter,
  output logic [width-1:0] capture,
  output logic             set_event
);

  logic       match;
  logic       cap_hit;
  logic [3:0] ctrl_mask;
  logic       unused_inputs;

  assign match = tick & ctrl[CTRL_EN] & (counter == compare);

`ifdef TIMER_BANK_CAPTURE_EN
  assign cap_hit   = cap_edge & ctrl[CTRL_CAP_EN];
  assign ctrl_mask = 4'b1111;
`else
  assign cap_hit   = 1'b0;
  assign ctrl_mask = 4'b0111;
`endif

  assign set_event     = match | cap_hit;
  assign unused_inputs = ^{cap_edge, wr_data};

  // CSR writes take priority over the tick-driven update of the same register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ctrl    <= '0;
      compare <= '1;
      counter <= '0;
    end else begin
      if (wr_compare) compare <= wr_data[width-1:0];

      if (wr_ctrl) ctrl <= wr_data[3:0] & ctrl_mask;
      else if (match && !ctrl[CTRL_AR]) ctrl[CTRL_EN] <= 1'b0;

      if (wr_counter) counter <= wr_data[width-1:0];
      else if (match) begin
        if (ctrl[CTRL_AR]) counter <= '0;
      end else if (tick && ctrl[CTRL_EN]) counter <= counter + width'(1);
    end
  end

`ifdef TIMER_BANK_CAPTURE_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) capture <= '0;
    else if (cap_hit) capture <= counter;
  end
`else
  assign capture = '0;
`endif

endmodule

// File: rtl/timer_bank.sv
// Bank of ntimers compare timers behind a CSR window with a shared prescaler.
// Define TIMER_BANK_CAPTURE_EN to add the capture_in port and capture registers.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter logic [3:0] csr_addr       = 4'h0,
  parameter int         ntimers        = 4,
  parameter int         width          = 32,
  parameter int         prescale_width = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [13:0]        csr_a,
  input  logic               csr_we,
  input  logic [31:0]        csr_di,
  output logic [31:0]        csr_do,
  output logic [ntimers-1:0] timer_irq,
  output logic               irq
`ifdef TIMER_BANK_CAPTURE_EN
  ,
  input  logic [ntimers-1:0] capture_in
`endif
);

`ifdef TIMER_BANK_CAPTURE_EN
  localparam logic CAP_PRESENT = 1'b1;
`else
  localparam logic CAP_PRESENT = 1'b0;
`endif

  logic                      sel;
  logic                      is_global;
  logic                      ch_we;
  logic                      gl_we;
  logic [2:0]                ch_idx;
  logic [1:0]                reg_idx;
  logic [prescale_width-1:0] prescale;
  logic [prescale_width-1:0] pre_cnt;
  logic                      tick;
  logic [ntimers-1:0]        pending;
  logic [ntimers-1:0]        set_events;
  logic [ntimers-1:0]        irq_en;
  logic [ntimers-1:0]        cap_edges;
  logic [3:0]                ch_ctrl    [ntimers];
  logic [width-1:0]          ch_compare [ntimers];
  logic [width-1:0]          ch_counter [ntimers];
  logic [width-1:0]          ch_capture [ntimers];
  logic [31:0]               rd_data;
  logic                      unused_addr;

  assign sel         = (csr_a[13:10] == csr_addr);
  assign is_global   = csr_a[9];
  assign ch_idx      = csr_a[6:4];
  assign reg_idx     = csr_a[1:0];
  assign ch_we       = csr_we & sel & ~is_global;
  assign gl_we       = csr_we & sel & is_global;
  assign tick        = (pre_cnt == prescale);
  assign unused_addr = ^{csr_a[8:7], csr_a[3:2]};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prescale <= '0;
      pre_cnt  <= '0;
    end else if (gl_we && reg_idx == GL_PRESCALE) begin
      prescale <= csr_di[prescale_width-1:0];
      pre_cnt  <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + prescale_width'(1);
    end
  end

`ifdef TIMER_BANK_CAPTURE_EN
  logic [ntimers-1:0] cap_s1;
  logic [ntimers-1:0] cap_s2;
  logic [ntimers-1:0] cap_s3;

  // Two-flop synchroniser plus one more stage for rising-edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cap_s1 <= '0;
      cap_s2 <= '0;
      cap_s3 <= '0;
    end else begin
      cap_s1 <= capture_in;
      cap_s2 <= cap_s1;
      cap_s3 <= cap_s2;
    end
  end

  assign cap_edges = cap_s2 & ~cap_s3;
`else
  assign cap_edges = '0;
`endif

  for (genvar i = 0; i < ntimers; i++) begin : g_ch
    logic hit;
    assign hit = ch_we && (ch_idx == 3'(i));

    timer_bank_channel #(.width(width)) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .tick       (tick),
      .wr_ctrl    (hit && reg_idx == CH_CTRL),
      .wr_compare (hit && reg_idx == CH_COMPARE),
      .wr_counter (hit && reg_idx == CH_COUNTER),
      .wr_data    (csr_di),
      .cap_edge   (cap_edges[i]),
      .ctrl       (ch_ctrl[i]),
      .compare    (ch_compare[i]),
      .counter    (ch_counter[i]),
      .capture    (ch_capture[i]),
      .set_event  (set_events[i])
    );

    assign irq_en[i] = ch_ctrl[i][CTRL_IRQ_EN];
  end

  // A new event in the same cycle as a write-one-to-clear keeps the bit set
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pending <= '0;
    else if (gl_we && reg_idx == GL_PENDING) pending <= (pending & ~csr_di[ntimers-1:0]) | set_events;
    else pending <= pending | set_events;
  end

  assign timer_irq = pending & irq_en;

  always_comb begin
    rd_data = '0;
    if (sel) begin
      if (is_global) begin
        case (gl_reg_e'(reg_idx))
          GL_PENDING:  rd_data = 32'(pending);
          GL_PRESCALE: rd_data = 32'(prescale);
          GL_INFO:     rd_data = make_info(ntimers, width, prescale_width, CAP_PRESENT);
          default:     rd_data = '0;
        endcase
      end else begin
        for (int i = 0; i < ntimers; i++) begin
          if (ch_idx == 3'(i)) begin
            case (ch_reg_e'(reg_idx))
              CH_CTRL:    rd_data = 32'(ch_ctrl[i]);
              CH_COMPARE: rd_data = 32'(ch_compare[i]);
              CH_COUNTER: rd_data = 32'(ch_counter[i]);
              default:    rd_data = 32'(ch_capture[i]);
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csr_do <= '0;
      irq    <= 1'b0;
    end else begin
      csr_do <= rd_data;
      irq    <= |timer_irq;
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Directed scoreboard bench for timer_bank (default parameters); capture
// scenarios are exercised when TIMER_BANK_CAPTURE_EN is defined.
module tb_timer_bank;

  localparam logic [1:0] R_CTRL     = 2'd0;
  localparam logic [1:0] R_COMPARE  = 2'd1;
  localparam logic [1:0] R_COUNTER  = 2'd2;
  localparam logic [1:0] R_CAPTURE  = 2'd3;
  localparam logic [1:0] G_PENDING  = 2'd0;
  localparam logic [1:0] G_PRESCALE = 2'd1;
  localparam logic [1:0] G_INFO     = 2'd2;
`ifdef TIMER_BANK_CAPTURE_EN
  localparam logic [31:0] INFO_EXP = 32'h0010_2084;
`else
  localparam logic [31:0] INFO_EXP = 32'h0010_2004;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic [3:0]  timer_irq;
  logic        irq;
`ifdef TIMER_BANK_CAPTURE_EN
  logic [3:0]  capture_in;
`endif

  int          checks = 0;
  int          failures = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  timer_bank dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .csr_a      (csr_a),
    .csr_we     (csr_we),
    .csr_di     (csr_di),
    .csr_do     (csr_do),
    .timer_irq  (timer_irq),
`ifdef TIMER_BANK_CAPTURE_EN
    .capture_in (capture_in),
`endif
    .irq        (irq)
  );

  function automatic logic [13:0] chAddr(input int ch, input logic [1:0] r);
    logic [2:0] c;
    c = ch[2:0];
    return {4'h0, 1'b0, 2'b00, c, 2'b00, r};
  endfunction

  function automatic logic [13:0] glAddr(input logic [1:0] r);
    return {4'h0, 1'b1, 7'd0, r};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic csrWrite(input logic [13:0] addr, input logic [31:0] data);
    csr_a  = addr;
    csr_di = data;
    csr_we = 1'b1;
    step(1);
    csr_we = 1'b0;
  endtask

  task automatic expectValue(input string tag, input logic [31:0] value);
    tag_q.push_back(tag);
    exp_q.push_back(value);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    string       tag;
    logic [31:0] expected;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=0x%08h expected=none", observed);
    end else begin
      tag      = tag_q.pop_front();
      expected = exp_q.pop_front();
      assert (observed === expected) else begin
        failures++;
        $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
    end
  endtask

  // Issue a CSR read, queue its expected data, compare once csr_do is registered
  task automatic applyStimulus(input logic [13:0] addr, input string tag, input logic [31:0] value);
    expectValue(tag, value);
    csr_a  = addr;
    csr_we = 1'b0;
    step(1);
    checkOutput(csr_do);
  endtask

  task automatic checkPort(input string tag, input logic [31:0] value, input logic [31:0] observed);
    expectValue(tag, value);
    checkOutput(observed);
  endtask

  task automatic checkResetRegs(input string pfx);
    applyStimulus(chAddr(0, R_CTRL),    {pfx, "_ctrl0"},    32'h0);
    applyStimulus(chAddr(1, R_COMPARE), {pfx, "_compare1"}, 32'hFFFF_FFFF);
    applyStimulus(chAddr(1, R_COUNTER), {pfx, "_counter1"}, 32'h0);
    applyStimulus(chAddr(2, R_CAPTURE), {pfx, "_capture2"}, 32'h0);
    applyStimulus(glAddr(G_PENDING),    {pfx, "_pending"},  32'h0);
    applyStimulus(glAddr(G_PRESCALE),   {pfx, "_prescale"}, 32'h0);
    applyStimulus(glAddr(G_INFO),       {pfx, "_info"},     INFO_EXP);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    csr_a     = '0;
    csr_we    = 1'b0;
    csr_di    = '0;
`ifdef TIMER_BANK_CAPTURE_EN
    capture_in = '0;
`endif
    step(2);
    checkPort("rst_csr_do", 32'h0, csr_do);
    checkPort("rst_timer_irq", 32'h0, 32'(timer_irq));
    checkPort("rst_irq", 32'h0, 32'(irq));
    sys_rst_n = 1'b1;
    step(1);

    checkResetRegs("rst");
    applyStimulus(glAddr(2'd3), "unmapped_global", 32'h0);
    applyStimulus(chAddr(5, R_COMPARE), "channel_out_of_range", 32'h0);
    applyStimulus({4'h1, 1'b1, 7'd0, G_INFO}, "other_bank", 32'h0);

    // prescale=0, compare=3, en|ar|irq_en: match on the 4th tick, reload to 0
    csrWrite(chAddr(0, R_COMPARE), 32'd3);
    csrWrite(chAddr(0, R_CTRL), 32'h7);
    step(3);
    checkPort("ar_before_match", 32'h0, 32'(timer_irq));
    step(1);
    checkPort("ar_match_irq", 32'h1, 32'(timer_irq));
    checkPort("ar_irq_latency", 32'h0, 32'(irq));
    applyStimulus(chAddr(0, R_COUNTER), "ar_reload", 32'h0);
    checkPort("ar_irq_reg", 32'h1, 32'(irq));
    applyStimulus(glAddr(G_PENDING), "ar_pending", 32'h1);
    csrWrite(chAddr(0, R_CTRL), 32'h0);
    csrWrite(glAddr(G_PENDING), 32'h1);
    checkPort("ar_cleared", 32'h0, 32'(timer_irq));

    // prescale=9, compare=2, ar=0: enable aligned to a tick, match 30 cycles later
    csrWrite(chAddr(1, R_COMPARE), 32'd2);
    csrWrite(glAddr(G_PRESCALE), 32'd9);
    step(9);
    csrWrite(chAddr(1, R_CTRL), 32'h5);
    step(29);
    checkPort("ps_before_match", 32'h0, 32'(timer_irq));
    step(1);
    checkPort("ps_match", 32'h2, 32'(timer_irq));
    applyStimulus(chAddr(1, R_CTRL), "ps_en_cleared", 32'h4);
    applyStimulus(chAddr(1, R_COUNTER), "ps_counter_hold", 32'd2);
    applyStimulus(glAddr(G_PRESCALE), "ps_prescale", 32'd9);
    step(20);
    applyStimulus(chAddr(1, R_COUNTER), "ps_counter_still", 32'd2);
    csrWrite(glAddr(G_PENDING), 32'h2);
    checkPort("ps_cleared", 32'h0, 32'(timer_irq));
    csrWrite(glAddr(G_PRESCALE), 32'd0);

    // W1C landing on the cycle of a second match: set wins
    csrWrite(chAddr(2, R_COMPARE), 32'd3);
    csrWrite(chAddr(2, R_CTRL), 32'h7);
    step(7);
    csrWrite(glAddr(G_PENDING), 32'h4);
    checkPort("w1c_set_wins", 32'h4, 32'(timer_irq));
    csrWrite(glAddr(G_PENDING), 32'h4);
    checkPort("w1c_clears", 32'h0, 32'(timer_irq));
    checkPort("w1c_irq_still_high", 32'h1, 32'(irq));
    step(1);
    checkPort("w1c_irq_dropped", 32'h0, 32'(irq));
    csrWrite(chAddr(2, R_CTRL), 32'h0);
    csrWrite(glAddr(G_PENDING), 32'h4);

    // Counter write on the match cycle beats the reload
    csrWrite(chAddr(3, R_COMPARE), 32'd3);
    csrWrite(chAddr(3, R_CTRL), 32'h7);
    step(3);
    csrWrite(chAddr(3, R_COUNTER), 32'h10);
    applyStimulus(chAddr(3, R_COUNTER), "cntwr_wins", 32'h10);
    csrWrite(chAddr(3, R_CTRL), 32'h0);
    csrWrite(glAddr(G_PENDING), 32'h8);
    checkPort("cntwr_cleared", 32'h0, 32'(timer_irq));

`ifdef TIMER_BANK_CAPTURE_EN
    csrWrite(chAddr(0, R_COUNTER), 32'h55);
    csrWrite(chAddr(0, R_CTRL), 32'hC);
    capture_in = 4'b0001;
    step(2);
    checkPort("cap_not_yet", 32'h0, 32'(timer_irq));
    step(1);
    checkPort("cap_pending", 32'h1, 32'(timer_irq));
    applyStimulus(chAddr(0, R_CAPTURE), "cap_value", 32'h55);
    capture_in = 4'b0000;
    csrWrite(chAddr(0, R_CTRL), 32'h0);
    csrWrite(glAddr(G_PENDING), 32'h1);
`else
    csrWrite(chAddr(0, R_CTRL), 32'h8);
    applyStimulus(chAddr(0, R_CTRL), "nocap_cap_en", 32'h0);
    applyStimulus(chAddr(0, R_CAPTURE), "nocap_capture", 32'h0);
`endif

    // Reset in the middle of activity
    csrWrite(chAddr(1, R_COUNTER), 32'd0);
    csrWrite(chAddr(1, R_COMPARE), 32'd100);
    csrWrite(chAddr(1, R_CTRL), 32'h3);
    csrWrite(chAddr(2, R_COUNTER), 32'd0);
    csrWrite(chAddr(2, R_COMPARE), 32'd1);
    csrWrite(chAddr(2, R_CTRL), 32'h7);
    step(4);
    checkPort("mid_irq_pending", 32'h4, 32'(timer_irq));
    applyStimulus(chAddr(1, R_COUNTER), "mid_count", 32'd7);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkPort("mid_rst_csr_do", 32'h0, csr_do);
    checkPort("mid_rst_timer_irq", 32'h0, 32'(timer_irq));
    checkPort("mid_rst_irq", 32'h0, 32'(irq));
    step(2);
    sys_rst_n = 1'b1;
    step(1);
    checkResetRegs("mid");
    applyStimulus(chAddr(2, R_CTRL), "mid_ctrl2", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
